// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
//
// Purpose:
//   Hazard and stall sequencer for the 5-stage core. It sits beside the
//   forwarding unit and decides when IF/ID must hold, when EXE gets a bubble,
//   and when the whole pipeline freezes while the SRAM controller is busy.
//   A watchdog bounds the SRAM wait. Two saturating counters record stall
//   activity.
//
// Parameters:
//   CNT_W    width of each stall performance counter
//   TIMEOUT  maximum consecutive busy cycles tolerated before ERROR (>= 1)
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   fwd_en            forwarding enabled (1) / disabled (0)
//   src1_ID, src2_ID  source registers of the instruction in ID
//   two_src_ID        ID instruction really reads src2_ID
//   dest_EXE          destination register in EXE
//   wb_en_EXE         EXE instruction writes back
//   mem_r_en_EXE      EXE instruction is a load
//   dest_MEM          destination register in MEM
//   wb_en_MEM         MEM instruction writes back
//   mem_req_MEM       MEM instruction accesses SRAM
//   sram_ready        SRAM access completes this cycle
//   freeze_IF         hold PC and IF/ID register
//   freeze_ID         hold ID stage
//   bubble_EXE        load a NOP into ID/EXE
//   freeze_all        hold every pipeline register
//   mem_timeout       sticky watchdog flag
//   state_o           RUN=0, MEM_WAIT=1, ERROR=2
//   hazard_stall_cnt  cycles with bubble_EXE=1 (saturating)
//   mem_stall_cnt     cycles with freeze_all=1 (saturating)
// -----------------------------------------------------------------------------
module hazard_stall_controller #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic [4:0]       src1_ID,
  input  logic [4:0]       src2_ID,
  input  logic             two_src_ID,
  input  logic [4:0]       dest_EXE,
  input  logic             wb_en_EXE,
  input  logic             mem_r_en_EXE,
  input  logic [4:0]       dest_MEM,
  input  logic             wb_en_MEM,
  input  logic             mem_req_MEM,
  input  logic             sram_ready,
  output logic             freeze_IF,
  output logic             freeze_ID,
  output logic             bubble_EXE,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] hazard_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt
);

  // Wait counter must be able to hold TIMEOUT itself.
  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W:0] TIMEOUT_V = (WAIT_W + 1)'(TIMEOUT);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  localparam int NUM_CNT = 2;

  // ---------------------------------------------------------------------------
  // RAW hazard detection
  // ---------------------------------------------------------------------------
  // r0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic reg_match(
    input logic [4:0] dest,
    input logic [4:0] src1,
    input logic [4:0] src2,
    input logic       two_src
  );
    return (dest != 5'd0) && ((dest == src1) || (two_src && (dest == src2)));
  endfunction

  logic hz_exe;
  logic hz_mem;
  logic hazard;
  logic mem_busy;

  assign hz_exe = wb_en_EXE & reg_match(dest_EXE, src1_ID, src2_ID, two_src_ID);
  assign hz_mem = wb_en_MEM & reg_match(dest_MEM, src1_ID, src2_ID, two_src_ID);

  // With forwarding, only a load in EXE cannot be bypassed in time; without
  // it, any pending write in EXE or MEM must drain first.
  assign hazard   = fwd_en ? (hz_exe & mem_r_en_EXE) : (hz_exe | hz_mem);
  assign mem_busy = mem_req_MEM & ~sram_ready;

  // ---------------------------------------------------------------------------
  // Memory-wait state machine with watchdog
  // ---------------------------------------------------------------------------
  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic [WAIT_W:0]   wait_inc;
  logic              timeout_reg;
  logic              timeout_next;

  // One extra bit so the increment never wraps before the compare.
  assign wait_inc = {1'b0, wait_cnt_reg} + (WAIT_W + 1)'(1);

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    timeout_next  = timeout_reg;
    case (state_reg)
      ST_RUN: begin
        wait_cnt_next = '0;
        if (mem_busy) begin
          // The busy cycle seen in RUN is the first counted wait cycle.
          state_next    = ST_MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (sram_ready) begin
          // Ready wins even if this cycle would have hit the limit.
          state_next    = ST_RUN;
          wait_cnt_next = '0;
        end else if (wait_inc >= TIMEOUT_V) begin
          state_next    = ST_ERROR;
          timeout_next  = 1'b1;
        end else begin
          wait_cnt_next = wait_inc[WAIT_W-1:0];
        end
      end
      ST_ERROR: begin
        // Terminal until reset.
        state_next = ST_ERROR;
      end
      default: begin
        state_next    = ST_RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_RUN;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall outputs
  // ---------------------------------------------------------------------------
  logic freeze_all_raw;
  logic bubble_raw;
  logic hold_front_raw;

  always_comb begin
    freeze_all_raw = 1'b0;
    case (state_reg)
      ST_RUN:      freeze_all_raw = mem_busy;
      // Dropping in the ready cycle lets the pipeline advance as the data lands.
      ST_MEM_WAIT: freeze_all_raw = ~sram_ready;
      ST_ERROR:    freeze_all_raw = 1'b1;
      default:     freeze_all_raw = 1'b0;
    endcase
  end

  // A global freeze masks the bubble: inserting a NOP while EXE is held would
  // destroy the instruction sitting there.
  assign bubble_raw     = hazard & ~freeze_all_raw;
  assign hold_front_raw = freeze_all_raw | hazard;

  // Every output reads zero while reset is asserted.
  assign freeze_all  = ~rst & freeze_all_raw;
  assign bubble_EXE  = ~rst & bubble_raw;
  assign freeze_IF   = ~rst & hold_front_raw;
  assign freeze_ID   = ~rst & hold_front_raw;
  assign mem_timeout = ~rst & timeout_reg;
  assign state_o     = rst ? ST_RUN : state_reg;

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  // Index 0: hazard bubbles, index 1: global freeze cycles (ERROR included).
  logic [NUM_CNT-1:0] cnt_qual;

  assign cnt_qual[0] = bubble_EXE;
  assign cnt_qual[1] = freeze_all;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (cnt_qual[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  assign hazard_stall_cnt = {CNT_W{~rst}} & g_cnt[0].cnt_reg;
  assign mem_stall_cnt    = {CNT_W{~rst}} & g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// Directed bench for hazard_stall_controller. Two instances share stimulus:
//   dut_a: default parameters (CNT_W=16, TIMEOUT=255)
//   dut_b: CNT_W=4, TIMEOUT=3 for watchdog and saturation cases
// -----------------------------------------------------------------------------
module tb_hazard_stall_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       fwd_en;
  logic [4:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
  logic       two_src_ID, wb_en_EXE, mem_r_en_EXE, wb_en_MEM;
  logic       mem_req_MEM, sram_ready;

  logic        a_freeze_IF, a_freeze_ID, a_bubble_EXE, a_freeze_all, a_mem_timeout;
  logic [1:0]  a_state;
  logic [15:0] a_hz_cnt, a_mem_cnt;

  logic        b_freeze_IF, b_freeze_ID, b_bubble_EXE, b_freeze_all, b_mem_timeout;
  logic [1:0]  b_state;
  logic [3:0]  b_hz_cnt, b_mem_cnt;

  hazard_stall_controller #(.CNT_W(16), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst), .fwd_en(fwd_en),
    .src1_ID(src1_ID), .src2_ID(src2_ID), .two_src_ID(two_src_ID),
    .dest_EXE(dest_EXE), .wb_en_EXE(wb_en_EXE), .mem_r_en_EXE(mem_r_en_EXE),
    .dest_MEM(dest_MEM), .wb_en_MEM(wb_en_MEM),
    .mem_req_MEM(mem_req_MEM), .sram_ready(sram_ready),
    .freeze_IF(a_freeze_IF), .freeze_ID(a_freeze_ID), .bubble_EXE(a_bubble_EXE),
    .freeze_all(a_freeze_all), .mem_timeout(a_mem_timeout), .state_o(a_state),
    .hazard_stall_cnt(a_hz_cnt), .mem_stall_cnt(a_mem_cnt)
  );

  hazard_stall_controller #(.CNT_W(4), .TIMEOUT(3)) dut_b (
    .clk(clk), .rst(rst), .fwd_en(fwd_en),
    .src1_ID(src1_ID), .src2_ID(src2_ID), .two_src_ID(two_src_ID),
    .dest_EXE(dest_EXE), .wb_en_EXE(wb_en_EXE), .mem_r_en_EXE(mem_r_en_EXE),
    .dest_MEM(dest_MEM), .wb_en_MEM(wb_en_MEM),
    .mem_req_MEM(mem_req_MEM), .sram_ready(sram_ready),
    .freeze_IF(b_freeze_IF), .freeze_ID(b_freeze_ID), .bubble_EXE(b_bubble_EXE),
    .freeze_all(b_freeze_all), .mem_timeout(b_mem_timeout), .state_o(b_state),
    .hazard_stall_cnt(b_hz_cnt), .mem_stall_cnt(b_mem_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic clear_in();
    fwd_en = 1'b0; src1_ID = '0; src2_ID = '0; two_src_ID = 1'b0;
    dest_EXE = '0; wb_en_EXE = 1'b0; mem_r_en_EXE = 1'b0;
    dest_MEM = '0; wb_en_MEM = 1'b0; mem_req_MEM = 1'b0; sram_ready = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    clear_in();
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_hazard_exe(input logic [4:0] r);
    fwd_en = 1'b0; wb_en_EXE = 1'b1; dest_EXE = r; src1_ID = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // ---- reset: outputs forced low even with busy and hazard inputs ----
    clear_in();
    rst = 1'b1;
    mem_req_MEM = 1'b1; sram_ready = 1'b0;
    fwd_en = 1'b1; mem_r_en_EXE = 1'b1; wb_en_EXE = 1'b1; dest_EXE = 5'd5; src1_ID = 5'd5;
    #2;
    chk("rst_freeze_all", a_freeze_all, 0);
    chk("rst_bubble", a_bubble_EXE, 0);
    chk("rst_freeze_IF", a_freeze_IF, 0);
    next_cycle();
    clear_in();
    rst = 1'b0;
    #1;
    chk("post_rst_state", a_state, 0);
    chk("post_rst_hz_cnt", a_hz_cnt, 0);
    chk("post_rst_mem_cnt", a_mem_cnt, 0);
    chk("post_rst_timeout", a_mem_timeout, 0);
    chk("post_rst_freeze_all", a_freeze_all, 0);

    // ---- load-use with forwarding ----
    next_cycle();
    fwd_en = 1'b1; mem_r_en_EXE = 1'b1; wb_en_EXE = 1'b1; dest_EXE = 5'd5; src1_ID = 5'd5;
    #1;
    chk("lu_bubble", a_bubble_EXE, 1);
    chk("lu_freeze_IF", a_freeze_IF, 1);
    chk("lu_freeze_ID", a_freeze_ID, 1);
    chk("lu_freeze_all", a_freeze_all, 0);
    chk("lu_cnt_before", a_hz_cnt, 0);
    next_cycle();
    clear_in();
    #1;
    chk("lu_bubble_gone", a_bubble_EXE, 0);
    chk("lu_cnt_after", a_hz_cnt, 1);
    next_cycle();
    fwd_en = 1'b1; mem_r_en_EXE = 1'b1; wb_en_EXE = 1'b1; dest_EXE = 5'd0; src1_ID = 5'd0;
    #1;
    chk("lu_r0_bubble", a_bubble_EXE, 0);
    chk("lu_r0_freeze_IF", a_freeze_IF, 0);
    next_cycle();
    clear_in();
    #1;
    chk("lu_r0_cnt", a_hz_cnt, 1);

    // ---- forwarding off, MEM-stage dependency on src2 ----
    next_cycle();
    fwd_en = 1'b0; wb_en_MEM = 1'b1; dest_MEM = 5'd7; src2_ID = 5'd7; two_src_ID = 1'b1;
    #1;
    chk("nofwd_mem_bubble", a_bubble_EXE, 1);
    next_cycle();
    two_src_ID = 1'b0;
    #1;
    chk("nofwd_one_src_bubble", a_bubble_EXE, 0);
    next_cycle();
    two_src_ID = 1'b1; fwd_en = 1'b1;
    #1;
    chk("fwd_mem_bubble", a_bubble_EXE, 0);
    next_cycle();
    clear_in();
    #1;
    chk("nofwd_cnt", a_hz_cnt, 2);

    // ---- SRAM wait of 4 busy cycles ----
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      mem_req_MEM = 1'b1; sram_ready = 1'b0;
      #1;
      chk("wait_freeze_all", a_freeze_all, 1);
      chk("wait_freeze_IF", a_freeze_IF, 1);
      chk("wait_state", a_state, (i == 0) ? 0 : 1);
    end
    next_cycle();
    sram_ready = 1'b1;
    #1;
    chk("ready_freeze_all", a_freeze_all, 0);
    chk("ready_state", a_state, 1);
    next_cycle();
    clear_in();
    #1;
    chk("wait_done_state", a_state, 0);
    chk("wait_mem_cnt", a_mem_cnt, 4);

    // ---- request completing immediately in RUN ----
    next_cycle();
    mem_req_MEM = 1'b1; sram_ready = 1'b1;
    #1;
    chk("fast_freeze_all", a_freeze_all, 0);
    next_cycle();
    clear_in();
    #1;
    chk("fast_state", a_state, 0);
    chk("fast_mem_cnt", a_mem_cnt, 4);

    // ---- hazard during a 3-cycle SRAM wait ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mem_req_MEM = 1'b1; sram_ready = 1'b0;
      set_hazard_exe(5'd4);
      #1;
      chk("prio_bubble", a_bubble_EXE, 0);
      chk("prio_freeze_all", a_freeze_all, 1);
    end
    next_cycle();
    sram_ready = 1'b1;
    #1;
    chk("prio_unfrozen_freeze_all", a_freeze_all, 0);
    chk("prio_unfrozen_bubble", a_bubble_EXE, 1);
    chk("prio_unfrozen_freeze_IF", a_freeze_IF, 1);
    next_cycle();
    clear_in();
    #1;
    chk("prio_hz_cnt", a_hz_cnt, 1);
    chk("prio_mem_cnt", a_mem_cnt, 3);

    // ---- watchdog on dut_b (TIMEOUT=3) ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mem_req_MEM = 1'b1; sram_ready = 1'b0;
      #1;
      chk("wd_busy_state", b_state, (i == 0) ? 0 : 1);
      chk("wd_busy_timeout", b_mem_timeout, 0);
      chk("wd_busy_freeze", b_freeze_all, 1);
    end
    next_cycle();
    #1;
    chk("wd_err_state", b_state, 2);
    chk("wd_err_timeout", b_mem_timeout, 1);
    chk("wd_err_freeze", b_freeze_all, 1);
    next_cycle();
    sram_ready = 1'b1;
    #1;
    chk("wd_ready_state", b_state, 2);
    chk("wd_ready_timeout", b_mem_timeout, 1);
    chk("wd_ready_freeze", b_freeze_all, 1);
    chk("wd_mem_cnt", b_mem_cnt, 4);
    next_cycle();
    rst = 1'b1;
    clear_in();
    #1;
    chk("wd_in_rst_state", b_state, 0);
    chk("wd_in_rst_freeze", b_freeze_all, 0);
    next_cycle();
    rst = 1'b0;
    #1;
    chk("wd_rst_state", b_state, 0);
    chk("wd_rst_timeout", b_mem_timeout, 0);
    chk("wd_rst_hz_cnt", b_hz_cnt, 0);
    chk("wd_rst_mem_cnt", b_mem_cnt, 0);

    // ---- ready arrives in the cycle the limit would be reached ----
    do_reset();
    next_cycle();
    mem_req_MEM = 1'b1; sram_ready = 1'b0;
    next_cycle();
    #1;
    chk("rw_wait_state", b_state, 1);
    next_cycle();
    sram_ready = 1'b1;
    #1;
    chk("rw_ready_freeze", b_freeze_all, 0);
    next_cycle();
    clear_in();
    #1;
    chk("rw_state", b_state, 0);
    chk("rw_timeout", b_mem_timeout, 0);

    // ---- counter saturation on dut_b (CNT_W=4) ----
    do_reset();
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      set_hazard_exe(5'd3);
      #1;
      if (i == 16) chk("sat_mid_b", b_hz_cnt, 15);
    end
    next_cycle();
    clear_in();
    #1;
    chk("sat_b_hz_cnt", b_hz_cnt, 15);
    chk("sat_a_hz_cnt", a_hz_cnt, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline hazard and stall sequencer for the 5-stage core; it sits beside the forwarding unit and decides when ID/IF must hold and when EXE gets a bubble.
- Detects RAW hazards between ID and EXE/MEM. When forwarding is enabled, only load-use hazards stall; when it is disabled, every RAW hazard stalls.
- Runs a state machine that freezes the whole pipeline while the SRAM controller is busy, with a wait watchdog.
- Keeps saturating stall performance counters.

Parameters:
- CNT_W, 16, width of each stall performance counter.
- TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before entering ERROR; minimum legal value 1.

Ports:
- clk  input  1  core clock; everything samples on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fwd_en  input  1  forwarding enabled (1) or disabled (0).
- src1_ID  input  5  first source register of the instruction in ID.
- src2_ID  input  5  second source register of the instruction in ID.
- two_src_ID  input  1  ID instruction really reads src2_ID (0 for immediate forms).
- dest_EXE  input  5  destination register in EXE.
- wb_en_EXE  input  1  EXE instruction writes back.
- mem_r_en_EXE  input  1  EXE instruction is a load.
- dest_MEM  input  5  destination register in MEM.
- wb_en_MEM  input  1  MEM instruction writes back.
- mem_req_MEM  input  1  MEM instruction accesses SRAM (load or store).
- sram_ready  input  1  SRAM controller completes the access this cycle.
- freeze_IF  output  1  hold the PC and the IF/ID register.
- freeze_ID  output  1  hold the ID stage.
- bubble_EXE  output  1  load a NOP into the ID/EXE register.
- freeze_all  output  1  hold every pipeline register.
- mem_timeout  output  1  sticky watchdog flag.
- state_o  output  2  current state: RUN=0, MEM_WAIT=1, ERROR=2.
- hazard_stall_cnt  output  CNT_W  cycles with bubble_EXE=1.
- mem_stall_cnt  output  CNT_W  cycles with freeze_all=1.

Behaviour:
- Reset values: state RUN, both counters 0, mem_timeout 0. All outputs are 0 in the reset cycle and in the cycle after, unless the inputs request a stall in that following cycle.
- Register 0 never causes a hazard. A match means the destination equals src1_ID, or equals src2_ID with two_src_ID=1, and the destination is nonzero.
- hz_exe = wb_en_EXE & match(dest_EXE).
- hz_mem = wb_en_MEM & match(dest_MEM).
- hazard = fwd_en ? (hz_exe & mem_r_en_EXE) : (hz_exe | hz_mem).
- mem_busy = mem_req_MEM & ~sram_ready.
- freeze_all (combinational, same cycle):
  - RUN: equals mem_busy.
  - MEM_WAIT: equals ~sram_ready.
  - ERROR: always 1.
- freeze_all has priority over hazard handling. When freeze_all=1, bubble_EXE=0, and freeze_IF/freeze_ID are also driven 1.
- With freeze_all=0 and hazard=1: freeze_IF=1, freeze_ID=1, bubble_EXE=1, all in the same cycle with zero latency.
- There is no hazard state. A load-use case clears naturally after one bubble, because the load moves to MEM.
- Transitions:
  - RUN -> MEM_WAIT when mem_busy=1.
  - MEM_WAIT -> RUN on the edge after sram_ready=1; freeze_all is already 0 in the ready cycle.
  - MEM_WAIT -> ERROR when the wait counter reaches TIMEOUT with sram_ready still 0.
  - ERROR: only rst leaves it.
- Wait counter (internal, width ceil(log2(TIMEOUT+1))):
  - Cleared in RUN.
  - Incremented each MEM_WAIT cycle with sram_ready=0.
  - The first busy cycle, which occurs in RUN, counts as 1.
  - TIMEOUT=N therefore allows N busy cycles; the next busy cycle enters ERROR.
- mem_timeout is set on the entry edge into ERROR and stays 1 until rst.
- sram_ready=1 in the same cycle the counter would reach TIMEOUT: ready wins and the block returns to RUN.
- Counters:
  - Each increments by 1 on the edge after a cycle in which its qualifying output was 1.
  - Each saturates at all-ones and never wraps.
  - mem_stall_cnt also counts ERROR cycles.
- rst asserted mid-MEM_WAIT or in ERROR: the block is in RUN on the next edge and the counters are cleared.
- mem_req_MEM with sram_ready=1 in the same RUN cycle: no freeze and no state change.

Test Plan:
- Load-use, forwarding on: fwd_en=1, mem_r_en_EXE=1, wb_en_EXE=1, dest_EXE=5, src1_ID=5 for 1 cycle -> exactly one cycle of freeze_IF=freeze_ID=bubble_EXE=1; hazard_stall_cnt goes 0->1. Same stimulus with dest_EXE=0 -> no stall.
- Forwarding off: fwd_en=0, wb_en_MEM=1, dest_MEM=7, src2_ID=7, two_src_ID=1 -> bubble_EXE=1. Same stimulus with two_src_ID=0 -> bubble_EXE=0. Same stimulus with fwd_en=1 -> bubble_EXE=0.
- SRAM wait: mem_req_MEM=1, sram_ready=0 for 4 cycles, then 1 -> freeze_all=1 for 4 cycles and 0 in the ready cycle; state_o follows 0,1,1,1,1,0; mem_stall_cnt=4.
- Priority: a hazard inside a 3-cycle SRAM wait -> bubble_EXE=0 throughout the freeze. The bubble appears in the first unfrozen cycle if the hazard is still present.
- Watchdog: TIMEOUT=3, sram_ready held 0 -> ERROR entered after the 3rd busy cycle; mem_timeout=1 and freeze_all=1 stay held while sram_ready rises. rst for 1 cycle -> state_o=0, mem_timeout=0, both counters 0.
- Saturation: CNT_W=4, hazard held for 20 cycles -> hazard_stall_cnt stops at 15.
